cook_time_entry: RTL and testbench



---
 rtl/cook_time_entry.sv | 187 ++++++++++++++++++
 tb/tb_cook_time_entry.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_time_entry.sv
// Front-panel cook-time entry: conditions four raw buttons into press events
// (auto-repeat on the two increment buttons), keeps a saturating cook time in
// seconds, arms/cancels the downstream timer and drives a registered mm:ss
// BCD display.
module cook_time_entry #(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int MAX_SECONDS  = 3599
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_min,
    input  logic        btn_tens,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        done,
    output logic [12:0] cookTime,
    output logic        timeinputdone,
    output logic [3:0]  disp_m_tens,
    output logic [3:0]  disp_m_ones,
    output logic [3:0]  disp_s_tens,
    output logic [3:0]  disp_s_ones,
    output logic [1:0]  state
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(REP_MAX + 1);
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);
    localparam logic [13:0]   MAX_C   = 14'(MAX_SECONDS);

    typedef enum logic [1:0] {
        S_EDIT = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    // Button bit order: 0 = min, 1 = tens, 2 = start, 3 = clear.
    logic [3:0]    raw;
    logic [3:0]    sync1, sync2, hist_q;
    logic [3:0]    edge_ev;
    logic [CW-1:0] rep_cnt [2];
    logic [1:0]    rep_phase;
    logic [1:0]    rep_fire;
    logic          done_q, done_rise;
    logic          ev_min, ev_tens, ev_start, ev_clear;
    state_t        state_q, state_d;
    logic [12:0]   cook_q, cook_d;
    logic [13:0]   inc, sum;
    logic [12:0]   sat;
    logic [12:0]   mins, secs;

    assign raw       = {btn_clear, btn_start, btn_tens, btn_min};
    assign edge_ev   = sync2 & ~hist_q;
    assign done_rise = done & ~done_q;
    assign ev_min    = edge_ev[0] | rep_fire[0];
    assign ev_tens   = edge_ev[1] | rep_fire[1];
    assign ev_start  = edge_ev[2];
    assign ev_clear  = edge_ev[3];

    // Two-flop synchronizer plus history flop per button, and done history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            hist_q <= '0;
            done_q <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            hist_q <= sync2;
            done_q <= done;
        end
    end

    // Repeat fires when the cycles since the last event reach the current
    // threshold: the initial delay first, then the repeat rate.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 2; i++) begin
            rep_fire[i] = sync2[i] & hist_q[i] &
                          (rep_cnt[i] == (rep_phase[i] ? RATE_C : DELAY_C));
        end
    end

    // Repeat counters: cleared by any low sample, restarted on every event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
            rep_phase <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!sync2[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (!hist_q[i]) begin
                    rep_cnt[i]   <= CW'(1);
                    rep_phase[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= CW'(1);
                    rep_phase[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Next state and cook time; one action per cycle, clear > start > min > tens.
    always_comb begin
        inc     = ev_min ? 14'd60 : 14'd10;
        sum     = {1'b0, cook_q} + inc;
        sat     = (sum > MAX_C) ? MAX_C[12:0] : sum[12:0];
        state_d = state_q;
        cook_d  = cook_q;
        case (state_q)
            S_RUN: begin
                if (ev_clear) begin
                    state_d = S_EDIT;
                    cook_d  = '0;
                end else if (done_rise) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (ev_clear) begin
                    state_d = S_EDIT;
                    cook_d  = '0;
                end else if (ev_start) begin
                    state_d = S_RUN;
                end else if (ev_min || ev_tens) begin
                    state_d = S_EDIT;
                    cook_d  = sat;
                end
            end
            default: begin
                // EDIT, and the unused 11 encoding which behaves as EDIT.
                state_d = S_EDIT;
                if (ev_clear) begin
                    cook_d = '0;
                end else if (ev_start) begin
                    if (cook_q != '0) state_d = S_RUN;
                end else if (ev_min || ev_tens) begin
                    cook_d = sat;
                end
            end
        endcase
    end

    // State, cook time and armed flag update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_EDIT;
            cook_q        <= '0;
            timeinputdone <= 1'b0;
        end else begin
            state_q       <= state_d;
            cook_q        <= cook_d;
            timeinputdone <= (state_d == S_RUN);
        end
    end

    // Split the current cook time into minutes and seconds.
    always_comb begin
        mins = cook_q / 13'd60;
        secs = cook_q % 13'd60;
    end

    // Registered BCD digits, one cycle behind cookTime.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_m_tens <= '0;
            disp_m_ones <= '0;
            disp_s_tens <= '0;
            disp_s_ones <= '0;
        end else begin
            disp_m_tens <= 4'(mins / 13'd10);
            disp_m_ones <= 4'(mins % 13'd10);
            disp_s_tens <= 4'(secs / 13'd10);
            disp_s_ones <= 4'(secs % 13'd10);
        end
    end

    assign cookTime = cook_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cook_time_entry.sv
// Bench for cook_time_entry: reset checks, a table of press scenarios,
// hand-written timing corner cases, then random stimulus against a
// per-cycle behavioural model built from the press/repeat/priority rules.
module tb_cook_time_entry;

    localparam int RD   = 8;
    localparam int RR   = 4;
    localparam int MAXS = 3599;
    localparam int ST_EDIT = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_FIN  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_min = 1'b0, btn_tens = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
    logic        done = 1'b0;
    logic [12:0] cookTime;
    logic        timeinputdone;
    logic [3:0]  disp_m_tens, disp_m_ones, disp_s_tens, disp_s_ones;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    cook_time_entry #(
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .MAX_SECONDS (MAXS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_min      (btn_min),
        .btn_tens     (btn_tens),
        .btn_start    (btn_start),
        .btn_clear    (btn_clear),
        .done         (done),
        .cookTime     (cookTime),
        .timeinputdone(timeinputdone),
        .disp_m_tens  (disp_m_tens),
        .disp_m_ones  (disp_m_ones),
        .disp_s_tens  (disp_s_tens),
        .disp_s_ones  (disp_s_ones),
        .state        (state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_digits(input string tag, input int secs_total);
        int m, s;
        m = secs_total / 60;
        s = secs_total % 60;
        check({tag, "_m_tens"}, 32'(disp_m_tens), 32'(m / 10));
        check({tag, "_m_ones"}, 32'(disp_m_ones), 32'(m % 10));
        check({tag, "_s_tens"}, 32'(disp_s_tens), 32'(s / 10));
        check({tag, "_s_ones"}, 32'(disp_s_ones), 32'(s % 10));
    endtask

    task automatic check_core(input string tag, input int c, input int st, input int tid);
        check({tag, "_cook"},  32'(cookTime), 32'(c));
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_tid"},   32'(timeinputdone), 32'(tid));
    endtask

    // Driver: one-hot button code 1=min 2=tens 4=start 8=clear.
    task automatic set_btn(input logic [3:0] code, input logic v);
        if (code[0]) btn_min   = v;
        if (code[1]) btn_tens  = v;
        if (code[2]) btn_start = v;
        if (code[3]) btn_clear = v;
    endtask

    task automatic press(input logic [3:0] code, input int count);
        for (int c = 0; c < count; c++) begin
            set_btn(code, 1'b1);
            repeat (4) @(negedge clk);
            set_btn(code, 1'b0);
            repeat (4) @(negedge clk);
        end
    endtask

    // Behavioural reference model (random phase).
    logic [4:0] hist[$];   // raw {done, clear, start, tens, min} per edge
    int run_min, run_tens;
    int m_state, m_cook, m_disp;

    function automatic bit fires(input int len);
        if (len == 1) return 1'b1;
        if (len - 1 >= RD && ((len - 1 - RD) % RR) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(5'b0);
        run_min  = 0;
        run_tens = 0;
        m_state  = ST_EDIT;
        m_cook   = 0;
        m_disp   = 0;
    endtask

    task automatic model_step();
        logic [4:0] cur, b2, b3;
        bit e_min, e_tens, e_start, e_clear, d_rise;
        int n;
        cur = {done, btn_clear, btn_start, btn_tens, btn_min};
        m_disp = m_cook;
        hist.push_back(cur);
        n = hist.size();
        b2 = hist[n-3];
        b3 = hist[n-4];
        d_rise = cur[4] & ~hist[n-2][4];
        run_min  = b2[0] ? run_min + 1 : 0;
        run_tens = b2[1] ? run_tens + 1 : 0;
        e_min   = (run_min > 0) && fires(run_min);
        e_tens  = (run_tens > 0) && fires(run_tens);
        e_start = b2[2] & ~b3[2];
        e_clear = b2[3] & ~b3[3];
        if (m_state == ST_RUN) begin
            if (e_clear) begin
                m_state = ST_EDIT;
                m_cook  = 0;
            end else if (d_rise) begin
                m_state = ST_FIN;
            end
        end else if (e_clear) begin
            m_state = ST_EDIT;
            m_cook  = 0;
        end else if (e_start) begin
            if (m_state == ST_FIN || m_cook > 0) m_state = ST_RUN;
        end else if (e_min || e_tens) begin
            m_cook  = m_cook + (e_min ? 60 : 10);
            if (m_cook > MAXS) m_cook = MAXS;
            m_state = ST_EDIT;
        end
        while (hist.size() > 8) void'(hist.pop_front());
    endtask

    typedef struct {
        logic [3:0] btn;
        int         count;
        int         exp_cook;
        int         exp_state;
        int         exp_tid;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'd1, 2, 120, ST_EDIT, 0};
        vecs[1] = '{4'd2, 3, 150, ST_EDIT, 0};
        vecs[2] = '{4'd4, 1, 150, ST_RUN,  1};
        vecs[3] = '{4'd1, 1, 150, ST_RUN,  1};
        vecs[4] = '{4'd8, 1, 0,   ST_EDIT, 0};
        vecs[5] = '{4'd4, 1, 0,   ST_EDIT, 0};
        vecs[6] = '{4'd2, 1, 10,  ST_EDIT, 0};
        vecs[7] = '{4'd8, 1, 0,   ST_EDIT, 0};

        // Reset
        repeat (3) @(negedge clk);
        check_core("reset", 0, ST_EDIT, 0);
        check_digits("reset", 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven press scenarios
        for (int i = 0; i < 8; i++) begin
            press(vecs[i].btn, vecs[i].count);
            check_core($sformatf("row%0d", i), vecs[i].exp_cook, vecs[i].exp_state, vecs[i].exp_tid);
            check_digits($sformatf("row%0d", i), vecs[i].exp_cook);
        end

        // 150 s entry then start latency: action lands at edge n+2
        press(4'd1, 2);
        press(4'd2, 3);
        check_digits("entry150", 150);
        btn_start = 1'b1;
        @(negedge clk);
        check("start_n0_state", 32'(state), ST_EDIT);
        @(negedge clk);
        check("start_n1_state", 32'(state), ST_EDIT);
        @(negedge clk);
        check_core("start_n2", 150, ST_RUN, 1);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);

        // done edge -> FINISHED on the very next edge, time retained
        done = 1'b1;
        @(negedge clk);
        check_core("done_fin", 150, ST_FIN, 0);
        done = 1'b0;
        repeat (2) @(negedge clk);
        press(4'd4, 1);
        check_core("fin_restart", 150, ST_RUN, 1);

        // clear event and done edge in the same cycle: clear wins
        btn_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        check_core("clear_vs_done", 0, ST_EDIT, 0);
        btn_clear = 1'b0;
        done = 1'b0;
        repeat (4) @(negedge clk);

        // FINISHED + tens -> EDIT with increment on the retained time
        press(4'd1, 1);
        press(4'd4, 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("fin2_state", 32'(state), ST_FIN);
        press(4'd2, 1);
        check_core("fin_tens", 70, ST_EDIT, 0);
        press(4'd8, 1);

        // Saturation at 59:59
        press(4'd1, 59);
        press(4'd2, 5);
        check_core("sat3590", 3590, ST_EDIT, 0);
        press(4'd1, 1);
        check_core("sat_min", 3599, ST_EDIT, 0);
        check_digits("sat_min", 3599);
        press(4'd2, 1);
        check_core("sat_tens", 3599, ST_EDIT, 0);
        press(4'd8, 1);

        // Auto-repeat: 18 synchronized-high cycles -> events at t0, +8, +12, +16
        btn_min = 1'b1;
        repeat (18) @(negedge clk);
        btn_min = 1'b0;
        repeat (6) @(negedge clk);
        check_core("repeat", 240, ST_EDIT, 0);
        check_digits("repeat", 240);

        // Asynchronous reset in RUN, between edges
        press(4'd4, 1);
        check("pre_rst_state", 32'(state), ST_RUN);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_core("async_rst", 0, ST_EDIT, 0);
        check_digits("async_rst", 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random stimulus against the reference model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_core("rand", m_cook, m_state, (m_state == ST_RUN) ? 1 : 0);
            check_digits("rand", m_disp);
            if ($urandom_range(0, 11) == 0) btn_min   = ~btn_min;
            if ($urandom_range(0, 7)  == 0) btn_tens  = ~btn_tens;
            if ($urandom_range(0, 19) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 299) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 14) == 0) done      = ~done;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
